// File: rtl/config_loader_pkg.sv
// config_loader_pkg: shared sizes, header field layout, bank encodings and FSM states for the config loader
package config_loader_pkg;
    localparam int phit_size    = 512;
    localparam int dwidth_RFadd = 5;
    localparam int depth_RF     = 32;
    localparam logic [1:0] sel_ctrl = 2'b01;
    localparam logic [1:0] sel_imm  = 2'b10;
    localparam int addr_lsb = 8;
    localparam int cnt_lsb  = 32;
    localparam int cnt_w    = 16;
    localparam int hdr_w    = cnt_lsb + cnt_w;
    typedef enum logic [2:0] {IDLE, HDR_CHK, DATA, DRAIN, DONE} state_t;
endpackage

// File: rtl/config_loader_if.sv
// config_loader_if: AXI-Stream beat channel from the host into the config loader
interface config_loader_if import config_loader_pkg::*; #(
    parameter int DATA_W = phit_size
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/cfg_hdr_decode.sv
// cfg_hdr_decode: splits a header beat into bank select, start address and count, and checks it stays in bounds
module cfg_hdr_decode import config_loader_pkg::*; #(
    parameter int ADDR_W = dwidth_RFadd,
    parameter int DEPTH  = depth_RF
) (
    input  logic [hdr_w-1:0]  hdr,
    output logic [1:0]        sel,
    output logic [ADDR_W-1:0] start,
    output logic [cnt_w-1:0]  count,
    output logic              hdr_ok
);
    localparam int SUM_W = ADDR_W + 17;
    logic [hdr_w-1:0] unused_hdr;
    logic [SUM_W-1:0] fin;
    assign unused_hdr = hdr;
    assign sel    = hdr[1:0];
    assign start  = hdr[addr_lsb +: ADDR_W];
    assign count  = hdr[cnt_lsb +: cnt_w];
    assign fin    = SUM_W'(start) + SUM_W'(count);
    assign hdr_ok = (sel == sel_ctrl || sel == sel_imm) && count != '0 && fin <= SUM_W'(DEPTH);
endmodule

// File: rtl/config_loader.sv
// config_loader: turns host AXI-Stream config packets into bounded, registered table write bursts
module config_loader import config_loader_pkg::*; #(
    parameter int DATA_W = phit_size,
    parameter int ADDR_W = dwidth_RFadd,
    parameter int DEPTH  = depth_RF
) (
    input  logic              clk,
    input  logic              rst_n,
    config_loader_if.slave    s_axis,
    output logic [1:0]        wr_en,
    output logic [ADDR_W-1:0] wr_add,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              err_clr
);
    state_t            state;
    logic              rdy;
    logic              acc;
    logic              hdr_ok;
    logic [hdr_w-1:0]  hdr;
    logic [1:0]        sel, sel_q;
    logic [ADDR_W-1:0] start, addr;
    logic [cnt_w-1:0]  count, rem;

    cfg_hdr_decode #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec (.hdr, .sel, .start, .count, .hdr_ok);

    assign acc           = s_axis.tvalid && rdy;
    assign s_axis.tready = rdy;
    assign busy          = state != IDLE;

    // rdy is the registered ready of the next state: only HDR_CHK and DONE refuse beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdy     <= 1'b0;
            hdr     <= '0;
            sel_q   <= '0;
            addr    <= '0;
            rem     <= '0;
            wr_en   <= '0;
            wr_add  <= '0;
            wr_data <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            rdy   <= 1'b1;
            wr_en <= '0;
            done  <= 1'b0;
            if (err_clr) err <= 1'b0;
            case (state)
                IDLE: if (acc) begin
                    hdr <= s_axis.tdata[hdr_w-1:0];
                    if (s_axis.tlast) err <= 1'b1;
                    else begin
                        state <= HDR_CHK;
                        rdy   <= 1'b0;
                    end
                end
                HDR_CHK: begin
                    addr  <= start;
                    rem   <= count;
                    sel_q <= sel;
                    state <= hdr_ok ? DATA : DRAIN;
                    if (!hdr_ok) err <= 1'b1;
                end
                DATA: if (acc) begin
                    wr_en   <= sel_q;
                    wr_add  <= addr;
                    wr_data <= s_axis.tdata;
                    addr    <= addr + 1'b1;
                    rem     <= rem - 1'b1;
                    if (rem == cnt_w'(1)) begin
                        state <= s_axis.tlast ? DONE : DRAIN;
                        rdy   <= !s_axis.tlast;
                        done  <= s_axis.tlast;
                        if (!s_axis.tlast) err <= 1'b1;
                    end else if (s_axis.tlast) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end
                end
                DRAIN: if (acc && s_axis.tlast) state <= IDLE;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: vector table, directed corner cases and random packets checked against a packet-level model
module tb_config_loader;
    import config_loader_pkg::*;
    localparam int DW = phit_size;
    localparam int AW = dwidth_RFadd;
    localparam int DP = depth_RF;

    typedef struct packed {
        logic [1:0]    en;
        logic [AW-1:0] add;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    typedef struct {
        logic [1:0] sel;
        int         start;
        int         n;
        int         len;
        int         gap;
        int         nwr;
        logic       e;
        int         d;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          err_clr = 1'b0;
    logic [1:0]    wr_en;
    logic [AW-1:0] wr_add;
    logic [DW-1:0] wr_data;
    logic          busy, done, err;
    int            n_chk = 0;
    int            n_fail = 0;
    int            done_cnt = 0;
    int            cyc = 0;
    wr_t           got[$];
    wr_t           exp_q[$];
    logic          m_err;
    int            m_done;

    config_loader_if #(.DATA_W(DW)) bus ();

    config_loader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_axis  (bus),
        .wr_en   (wr_en),
        .wr_add  (wr_add),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (wr_en != 2'b00) begin
            got.push_back(wr_t'{en: wr_en, add: wr_add, data: wr_data, cyc: cyc});
            chk("wr_en_onehot", DW'(wr_en == 2'b01 || wr_en == 2'b10), DW'(1));
        end
        if (done) done_cnt++;
    end

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] mkhdr(input logic [1:0] sel, input int start, input int n);
        logic [DW-1:0] h;
        h = rnd();
        h[1:0] = sel;
        h[8 +: AW] = AW'(start);
        h[32 +: 16] = 16'(n);
        return h;
    endfunction

    task automatic put(input logic [DW-1:0] d, input logic l, input int gap, output int c);
        int t;
        t = 0;
        bus.tvalid = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.tdata = d;
        bus.tlast = l;
        bus.tvalid = 1'b1;
        while (!bus.tready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t == 100) chk("tready_timeout", DW'(0), DW'(1));
        @(posedge clk);
        #1;
        c = cyc;
        bus.tvalid = 1'b0;
        bus.tlast = 1'b0;
    endtask

    task automatic settle();
        int t;
        t = 0;
        repeat (2) @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t == 200) chk("idle_timeout", DW'(0), DW'(1));
        #1;
    endtask

    task automatic clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // packet-level model: a header is good when the bank is legal and [start, start+n) fits the bank;
    // a good packet writes its first min(n, len) beats in order, anything but an exact length is an error
    task automatic run_pkt(input logic [1:0] sel, input int start, input int n, input int len, input int gap);
        logic [DW-1:0] b;
        int            c;
        logic          ok;
        ok = (sel == 2'b01 || sel == 2'b10) && n >= 1 && start + n <= DP && len >= 1;
        got.delete();
        exp_q.delete();
        done_cnt = 0;
        m_err = !ok || len != n;
        m_done = (ok && len == n) ? 1 : 0;
        put(mkhdr(sel, start, n), len == 0, $urandom_range(0, gap), c);
        for (int i = 0; i < len; i++) begin
            b = rnd();
            put(b, i == len - 1, $urandom_range(0, gap), c);
            if (ok && i < n) exp_q.push_back(wr_t'{en: sel, add: AW'(start + i), data: b, cyc: c});
        end
        settle();
    endtask

    task automatic compare(input string nm);
        chk({nm, " nwrites"}, DW'(got.size()), DW'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s wr%0d en", nm, i), DW'(got[i].en), DW'(exp_q[i].en));
            chk($sformatf("%s wr%0d add", nm, i), DW'(got[i].add), DW'(exp_q[i].add));
            chk($sformatf("%s wr%0d data", nm, i), got[i].data, exp_q[i].data);
            chk($sformatf("%s wr%0d cycle", nm, i), DW'(got[i].cyc), DW'(exp_q[i].cyc));
        end
        chk({nm, " err"}, DW'(err), DW'(m_err));
        chk({nm, " done"}, DW'(done_cnt), DW'(m_done));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vt[12];
        logic [DW-1:0] h;
        int            c, c0, rn, rs, rl, rd;
        logic [1:0]    rsel;
        vt[0]  = '{2'b01, 3, 4, 4, 0, 4, 1'b0, 1};
        vt[1]  = '{2'b10, DP - 2, 2, 2, 2, 2, 1'b0, 1};
        vt[2]  = '{2'b01, DP - 1, 2, 5, 0, 0, 1'b1, 0};
        vt[3]  = '{2'b01, 0, 1, 1, 0, 1, 1'b0, 1};
        vt[4]  = '{2'b11, 0, 2, 2, 0, 0, 1'b1, 0};
        vt[5]  = '{2'b01, 4, 0, 3, 1, 0, 1'b1, 0};
        vt[6]  = '{2'b01, 5, 4, 2, 0, 2, 1'b1, 0};
        vt[7]  = '{2'b10, 10, 2, 3, 0, 2, 1'b1, 0};
        vt[8]  = '{2'b00, 1, 1, 1, 0, 0, 1'b1, 0};
        vt[9]  = '{2'b01, 0, DP, DP, 0, DP, 1'b0, 1};
        vt[10] = '{2'b01, 0, 1, 0, 0, 0, 1'b1, 0};
        vt[11] = '{2'b10, DP - 1, 1, 1, 3, 1, 1'b0, 1};
        bus.tvalid = 1'b0;
        bus.tlast = 1'b0;
        bus.tdata = '0;
        repeat (3) @(negedge clk);
        chk("rst tready", DW'(bus.tready), DW'(0));
        chk("rst wr_en", DW'(wr_en), DW'(0));
        chk("rst wr_add", DW'(wr_add), DW'(0));
        chk("rst wr_data", wr_data, DW'(0));
        chk("rst busy", DW'(busy), DW'(0));
        chk("rst done", DW'(done), DW'(0));
        chk("rst err", DW'(err), DW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("tready after release", DW'(bus.tready), DW'(1));

        for (int i = 0; i < 12; i++) begin
            clr();
            run_pkt(vt[i].sel, vt[i].start, vt[i].n, vt[i].len, vt[i].gap);
            chk($sformatf("vec%0d table nwr", i), DW'(got.size()), DW'(vt[i].nwr));
            chk($sformatf("vec%0d table err", i), DW'(err), DW'(vt[i].e));
            chk($sformatf("vec%0d table done", i), DW'(done_cnt), DW'(vt[i].d));
            compare($sformatf("vec%0d", i));
            if (vt[i].e) begin
                clr();
                chk($sformatf("vec%0d err_clr", i), DW'(err), DW'(0));
            end
        end

        // full-rate timing: header at edge 0, data at edges 2..N+1, done in cycle N+2, ready again after
        clr();
        got.delete();
        done_cnt = 0;
        put(mkhdr(2'b01, 7, 3), 1'b0, 0, c0);
        put(rnd(), 1'b0, 0, c);
        chk("first data edge", DW'(c), DW'(c0 + 2));
        put(rnd(), 1'b0, 0, c);
        put(rnd(), 1'b1, 0, c);
        chk("last data edge", DW'(c), DW'(c0 + 4));
        @(negedge clk);
        chk("done cycle done", DW'(done), DW'(1));
        chk("done cycle tready", DW'(bus.tready), DW'(0));
        @(negedge clk);
        chk("post done tready", DW'(bus.tready), DW'(1));
        chk("post done busy", DW'(busy), DW'(0));
        chk("post done pulse", DW'(done), DW'(0));
        chk("timing nwrites", DW'(got.size()), DW'(3));
        if (got.size() == 3) begin
            chk("timing first write cycle", DW'(got[0].cyc), DW'(c0 + 2));
            chk("timing first write add", DW'(got[0].add), DW'(7));
            chk("timing last write add", DW'(got[2].add), DW'(9));
        end
        chk("timing done count", DW'(done_cnt), DW'(1));

        // an error set in the same cycle as err_clr wins
        clr();
        err_clr = 1'b1;
        put(mkhdr(2'b01, 0, 1), 1'b1, 0, c);
        err_clr = 1'b0;
        @(negedge clk);
        chk("err set beats clear", DW'(err), DW'(1));
        clr();
        chk("err cleared", DW'(err), DW'(0));

        // reset in the middle of a packet after two of four data beats
        got.delete();
        put(mkhdr(2'b01, 0, 4), 1'b0, 0, c);
        put(rnd(), 1'b0, 0, c);
        put(rnd(), 1'b0, 0, c);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst wr_en", DW'(wr_en), DW'(0));
        chk("midrst wr_add", DW'(wr_add), DW'(0));
        chk("midrst wr_data", wr_data, DW'(0));
        chk("midrst busy", DW'(busy), DW'(0));
        chk("midrst tready", DW'(bus.tready), DW'(0));
        chk("midrst err", DW'(err), DW'(0));
        chk("midrst writes before", DW'(got.size()), DW'(2));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("midrst no write after", DW'(got.size()), DW'(2));
        chk("midrst idle ready", DW'(bus.tready), DW'(1));

        for (int k = 0; k < 40; k++) begin
            rn = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 6));
            rs = $urandom_range(0, DP - 1);
            if (k % 3 == 0 && rn <= DP) rs = DP - rn + int'($urandom_range(0, 1));
            if (rs > DP - 1) rs = DP - 1;
            rd = $urandom_range(0, 3);
            rl = (rd == 0) ? 0 : rn + rd - 2;
            if (rd != 0 && rl < 1) rl = 1;
            if (rl > 8) rl = $urandom_range(1, 4);
            rsel = ($urandom_range(0, 4) > 0) ? (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10) : 2'($urandom_range(0, 3));
            clr();
            run_pkt(rsel, rs, rn, rl, 2);
            compare($sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
